bit_serial_sequencer: RTL and testbench
=======================================

// Module: bit_serial_sequencer
// PURPOSE
//  Parametrised control sequencer for the bit-serial datapath; next generation of the opcode decoder.
//  Accepts one instruction per valid/ready handshake and runs WORD_W serial shift cycles, LSB first.
//  Then issues one writeback/PC-increment cycle.
//  Drives the serial ALU function select, the shift enables and the regfile write strobe.
//  Adds SUB carry-init, HALT, illegal-opcode flagging and an optional early-accept pipeline.
// PARAMETERS
//  WORD_W      8   operand width = serial cycles per ALU op (>=2)
//  OPC_W       3   opcode width (>=3)
//  ALU_FUNC_W  3   alu_func width
//  CNT_W       $clog2(WORD_W)  bit-counter width (derived, localparam)
// PORTS
//  clk          in   1           clock, all state on posedge
//  rst          in   1           synchronous, active-high reset
//  instr_valid  in   1           opcode valid from fetch
//  instr_ready  out  1           sequencer can accept opcode this cycle
//  opcode       in   OPC_W       0 NOP,1 ADD,2 SUB,3 AND,4 OR,5 XOR,6 MOV,7 HALT; >7 illegal
//  alu_func     out  ALU_FUNC_W  0 RADD,1 RSUB,2 RAND,3 ROR,4 RXOR,5 RPASS
//  shift        out  1           shift operand/result registers one bit
//  carry_init   out  1           force ALU carry-in=1 (first SUB bit only)
//  last_bit     out  1           final serial bit this cycle
//  write        out  1           regfile writeback strobe
//  pc_incr      out  1           PC increment strobe
//  halted       out  1           sequencer stopped by HALT
//  illegal_op   out  1           one-cycle pulse: illegal opcode accepted
// BEHAVIOUR
//  - FSM states: IDLE, EXEC, WB, HALT. Registers: state, op_q, cnt (CNT_W).
//  - Outputs decode from registered state/op_q/cnt only; no comb path from instr_valid/opcode.
//  - Reset: state=IDLE, cnt=0, op_q=NOP. Outputs: instr_ready=1, all others 0.
//  - Accept = instr_valid & instr_ready; opcode is sampled into op_q on that edge.
//  - IDLE: instr_ready=1.
//    ADD..MOV accepted -> EXEC, cnt=0.
//    NOP or illegal accepted -> WB; illegal_op=1 in that WB cycle.
//    HALT accepted -> HALT.
//  - EXEC: shift=1, alu_func per op_q, cnt+=1 each cycle.
//    carry_init=1 only when cnt==0 and op_q==SUB.
//    At cnt==WORD_W-1: last_bit=1 and next state is WB. cnt returns to 0, never exceeds WORD_W-1.
//  - WB (one cycle): pc_incr=1; write=1 unless op_q is NOP or illegal. Next state IDLE.
//  - HALT: halted=1, instr_ready=0, all strobes 0. instr_valid is ignored; only rst exits.
//  - alu_func=0 outside EXEC.
//  - Latency, accept at edge T:
//    ALU op: shift T+1..T+WORD_W, write/pc_incr T+WORD_W+1, ready again T+WORD_W+2.
//    NOP: pc_incr T+1, ready T+2.
//  - Reset mid-EXEC/WB: abort; next cycle is IDLE with no write/pc_incr pulse.
//  - instr_valid with instr_ready=0: opcode is not consumed; fetch must hold it.
// CONFIGURATION
//  SEQ_EARLY_ACCEPT_EN defined:
//    instr_ready=1 in WB as well; accept in WB goes straight to EXEC/WB/HALT as from IDLE.
//    Back-to-back ALU ops therefore take WORD_W+1 cycles each.
//    WB strobes still reflect the retiring op_q; the new opcode loads on the same edge.
//  Not defined: instr_ready=1 only in IDLE; WORD_W+2 cycles per ALU op.
// TESTING (WORD_W=8)
//  rst high 2 cycles, then low -> instr_ready=1, every other output 0, halted=0.
//  ADD at T -> shift=1 T+1..T+8, alu_func=0, last_bit only T+8,
//    write=pc_incr=1 at T+9, instr_ready=1 at T+10.
//  SUB at T -> alu_func=1 T+1..T+8, carry_init=1 at T+1 only; NOP at T -> pc_incr T+1, write=0.
//  HALT at T -> halted=1 from T+1; ADD offered for 20 cycles never accepted.
//    rst -> IDLE, halted=0.
//  ADD at T, rst at T+5 -> T+6 is IDLE, no write/pc_incr pulse until a new accept.
//  SEQ_EARLY_ACCEPT_EN: two ADDs valid back-to-back -> second accepted at T+9 with write=1,
//    shift resumes at T+10; without the macro, second accepted at T+10.

Source files
------------

// File: rtl/bit_serial_sequencer.sv
// Bit-serial datapath control sequencer: one instruction per handshake, WORD_W LSB-first shift
// cycles, then a writeback/PC-increment cycle. Optional macro SEQ_EARLY_ACCEPT_EN enables accept in WB.
module bit_serial_sequencer #(
    parameter int WORD_W     = 8,
    parameter int OPC_W      = 3,
    parameter int ALU_FUNC_W = 3
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_instr_valid,
    output logic                  o_instr_ready,
    input  logic [OPC_W-1:0]      i_opcode,
    output logic [ALU_FUNC_W-1:0] o_alu_func,
    output logic                  o_shift,
    output logic                  o_carry_init,
    output logic                  o_last_bit,
    output logic                  o_write,
    output logic                  o_pc_incr,
    output logic                  o_halted,
    output logic                  o_illegal_op
);

    localparam int CNT_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WORD_W - 1);

    localparam logic [OPC_W-1:0] OP_NOP  = OPC_W'(0);
    localparam logic [OPC_W-1:0] OP_ADD  = OPC_W'(1);
    localparam logic [OPC_W-1:0] OP_SUB  = OPC_W'(2);
    localparam logic [OPC_W-1:0] OP_AND  = OPC_W'(3);
    localparam logic [OPC_W-1:0] OP_OR   = OPC_W'(4);
    localparam logic [OPC_W-1:0] OP_XOR  = OPC_W'(5);
    localparam logic [OPC_W-1:0] OP_MOV  = OPC_W'(6);
    localparam logic [OPC_W-1:0] OP_HALT = OPC_W'(7);

    localparam logic [ALU_FUNC_W-1:0] F_RADD  = ALU_FUNC_W'(0);
    localparam logic [ALU_FUNC_W-1:0] F_RSUB  = ALU_FUNC_W'(1);
    localparam logic [ALU_FUNC_W-1:0] F_RAND  = ALU_FUNC_W'(2);
    localparam logic [ALU_FUNC_W-1:0] F_ROR   = ALU_FUNC_W'(3);
    localparam logic [ALU_FUNC_W-1:0] F_RXOR  = ALU_FUNC_W'(4);
    localparam logic [ALU_FUNC_W-1:0] F_RPASS = ALU_FUNC_W'(5);

`ifdef SEQ_EARLY_ACCEPT_EN
    localparam logic EARLY_ACCEPT = 1'b1;
`else
    localparam logic EARLY_ACCEPT = 1'b0;
`endif

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_WB,
        S_HALT
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [OPC_W-1:0] r_op_q;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_accept;

    // Any opcode bit above the low three marks an encoding outside the defined set.
    function automatic logic is_illegal(input logic [OPC_W-1:0] op);
        logic [OPC_W-1:0] hi;
        hi = op >> 3;
        return |hi;
    endfunction

    function automatic logic is_alu_op(input logic [OPC_W-1:0] op);
        return !is_illegal(op) && (op != OP_NOP) && (op != OP_HALT);
    endfunction

    function automatic state_t dispatch(input logic [OPC_W-1:0] op);
        state_t s;
        if (is_illegal(op) || (op == OP_NOP)) begin
            s = S_WB;
        end else if (op == OP_HALT) begin
            s = S_HALT;
        end else begin
            s = S_EXEC;
        end
        return s;
    endfunction

    function automatic logic [ALU_FUNC_W-1:0] func_for(input logic [OPC_W-1:0] op);
        logic [ALU_FUNC_W-1:0] f;
        case (op)
            OP_ADD:  f = F_RADD;
            OP_SUB:  f = F_RSUB;
            OP_AND:  f = F_RAND;
            OP_OR:   f = F_ROR;
            OP_XOR:  f = F_RXOR;
            OP_MOV:  f = F_RPASS;
            default: f = F_RADD;
        endcase
        return f;
    endfunction

    assign w_accept = i_instr_valid & o_instr_ready;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_op_q  <= OP_NOP;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_accept) begin
                r_op_q <= i_opcode;
            end
        end
    end

    // Bit counter only advances in EXEC and wraps to 0 on the last serial bit.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = '0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = dispatch(i_opcode);
                end
            end
            S_EXEC: begin
                if (r_cnt == CNT_LAST) begin
                    w_state_nxt = S_WB;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            S_WB: begin
                if (EARLY_ACCEPT && w_accept) begin
                    w_state_nxt = dispatch(i_opcode);
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_HALT: begin
                w_state_nxt = S_HALT;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Outputs depend only on registered state so fetch timing never reaches the datapath controls.
    always_comb begin
        o_instr_ready = 1'b0;
        o_alu_func    = F_RADD;
        o_shift       = 1'b0;
        o_carry_init  = 1'b0;
        o_last_bit    = 1'b0;
        o_write       = 1'b0;
        o_pc_incr     = 1'b0;
        o_halted      = 1'b0;
        o_illegal_op  = 1'b0;
        case (r_state)
            S_IDLE: begin
                o_instr_ready = 1'b1;
            end
            S_EXEC: begin
                o_shift      = 1'b1;
                o_alu_func   = func_for(r_op_q);
                o_carry_init = (r_cnt == '0) && (r_op_q == OP_SUB);
                o_last_bit   = (r_cnt == CNT_LAST);
            end
            S_WB: begin
                o_instr_ready = EARLY_ACCEPT;
                o_pc_incr     = 1'b1;
                o_write       = is_alu_op(r_op_q);
                o_illegal_op  = is_illegal(r_op_q);
            end
            S_HALT: begin
                o_halted = 1'b1;
            end
            default: begin
                o_instr_ready = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_bit_serial_sequencer.sv
// Self-checking bench for bit_serial_sequencer: opcode vector table driven through a
// per-cycle expected-output scoreboard, plus hand sequences for HALT, reset abort and back-to-back issue.
module tb_bit_serial_sequencer;

    localparam int WORD_W     = 8;
    localparam int OPC_W      = 3;
    localparam int ALU_FUNC_W = 3;

`ifdef SEQ_EARLY_ACCEPT_EN
    localparam logic EARLY = 1'b1;
`else
    localparam logic EARLY = 1'b0;
`endif

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  instrValid;
    logic                  instrReady;
    logic [OPC_W-1:0]      opcode;
    logic [ALU_FUNC_W-1:0] aluFunc;
    logic                  shift;
    logic                  carryInit;
    logic                  lastBit;
    logic                  write;
    logic                  pcIncr;
    logic                  halted;
    logic                  illegalOp;

    bit_serial_sequencer #(
        .WORD_W    (WORD_W),
        .OPC_W     (OPC_W),
        .ALU_FUNC_W(ALU_FUNC_W)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_instr_valid(instrValid),
        .o_instr_ready(instrReady),
        .i_opcode     (opcode),
        .o_alu_func   (aluFunc),
        .o_shift      (shift),
        .o_carry_init (carryInit),
        .o_last_bit   (lastBit),
        .o_write      (write),
        .o_pc_incr    (pcIncr),
        .o_halted     (halted),
        .o_illegal_op (illegalOp)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic                  ready;
        logic [ALU_FUNC_W-1:0] func;
        logic                  shift;
        logic                  carry;
        logic                  last;
        logic                  write;
        logic                  pc;
        logic                  halted;
        logic                  illegal;
    } outs_t;

    typedef struct {
        logic [OPC_W-1:0]      opc;
        string                 name;
        int                    serialCycles;
        logic [ALU_FUNC_W-1:0] func;
        logic                  carryFirst;
        logic                  write;
    } vec_t;

    vec_t  vecs[7];
    outs_t expQ[$];
    int    checks   = 0;
    int    failures = 0;

    function automatic outs_t idleVec();
        outs_t v;
        v       = '0;
        v.ready = 1'b1;
        return v;
    endfunction

    function automatic outs_t haltVec();
        outs_t v;
        v        = '0;
        v.halted = 1'b1;
        return v;
    endfunction

    // Expected cycles after accept: serial bits, writeback, then the idle cycle.
    task automatic pushVec(input vec_t v, input logic withIdle);
        outs_t e;
        for (int i = 0; i < v.serialCycles; i++) begin
            e       = '0;
            e.shift = 1'b1;
            e.func  = v.func;
            e.carry = v.carryFirst && (i == 0);
            e.last  = (i == v.serialCycles - 1);
            expQ.push_back(e);
        end
        e       = '0;
        e.pc    = 1'b1;
        e.write = v.write;
        e.ready = EARLY;
        expQ.push_back(e);
        if (withIdle) begin
            expQ.push_back(idleVec());
        end
    endtask

    task automatic checkOutput(input string name);
        outs_t got;
        outs_t exp;
        got = '{ready: instrReady, func: aluFunc, shift: shift, carry: carryInit, last: lastBit,
                write: write, pc: pcIncr, halted: halted, illegal: illegalOp};
        checks++;
        if (expQ.size() == 0) begin
            failures++;
            $display("[TB] FAIL %s: scoreboard empty, got %h", name, got);
        end else begin
            exp = expQ.pop_front();
            if (got !== exp) begin
                failures++;
                $display("[TB] FAIL %s @%0t: got rdy=%b fn=%0d sh=%b ci=%b lb=%b wr=%b pc=%b hl=%b il=%b, expected rdy=%b fn=%0d sh=%b ci=%b lb=%b wr=%b pc=%b hl=%b il=%b",
                         name, $time, got.ready, got.func, got.shift, got.carry, got.last, got.write,
                         got.pc, got.halted, got.illegal, exp.ready, exp.func, exp.shift, exp.carry,
                         exp.last, exp.write, exp.pc, exp.halted, exp.illegal);
            end
        end
    endtask

    task automatic drainChecks(input string name);
        while (expQ.size() > 0) begin
            checkOutput(name);
            if (expQ.size() > 0) begin
                @(negedge clk);
            end
        end
    endtask

    // Offer one opcode for a single edge from IDLE, then check every following cycle.
    task automatic applyStimulus(input vec_t v);
        @(negedge clk);
        instrValid = 1'b1;
        opcode     = v.opc;
        @(negedge clk);
        instrValid = 1'b0;
        pushVec(v, 1'b1);
        drainChecks(v.name);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        vecs[0] = '{opc: 3'd0, name: "NOP", serialCycles: 0,      func: 3'd0, carryFirst: 1'b0, write: 1'b0};
        vecs[1] = '{opc: 3'd1, name: "ADD", serialCycles: WORD_W, func: 3'd0, carryFirst: 1'b0, write: 1'b1};
        vecs[2] = '{opc: 3'd2, name: "SUB", serialCycles: WORD_W, func: 3'd1, carryFirst: 1'b1, write: 1'b1};
        vecs[3] = '{opc: 3'd3, name: "AND", serialCycles: WORD_W, func: 3'd2, carryFirst: 1'b0, write: 1'b1};
        vecs[4] = '{opc: 3'd4, name: "OR",  serialCycles: WORD_W, func: 3'd3, carryFirst: 1'b0, write: 1'b1};
        vecs[5] = '{opc: 3'd5, name: "XOR", serialCycles: WORD_W, func: 3'd4, carryFirst: 1'b0, write: 1'b1};
        vecs[6] = '{opc: 3'd6, name: "MOV", serialCycles: WORD_W, func: 3'd5, carryFirst: 1'b0, write: 1'b1};

        rst        = 1'b1;
        instrValid = 1'b0;
        opcode     = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        expQ.push_back(idleVec());
        checkOutput("reset");

        foreach (vecs[i]) begin
            applyStimulus(vecs[i]);
        end

        // HALT blocks every later offer until reset.
        @(negedge clk);
        instrValid = 1'b1;
        opcode     = 3'd7;
        @(negedge clk);
        opcode = 3'd1;
        for (int i = 0; i < 21; i++) begin
            expQ.push_back(haltVec());
            checkOutput("halt_hold");
            @(negedge clk);
        end
        instrValid = 1'b0;
        rst        = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        expQ.push_back(idleVec());
        checkOutput("halt_reset");

        // Reset during EXEC aborts without any writeback pulse.
        @(negedge clk);
        instrValid = 1'b1;
        opcode     = 3'd1;
        @(negedge clk);
        instrValid = 1'b0;
        pushVec(vecs[1], 1'b1);
        for (int i = 0; i < 5; i++) begin
            checkOutput("abort_exec");
            @(negedge clk);
        end
        expQ.delete();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            expQ.push_back(idleVec());
            checkOutput("abort_idle");
            @(negedge clk);
        end

        // Two ADDs offered back to back; second accept timing depends on early accept.
        instrValid = 1'b1;
        opcode     = 3'd1;
        @(negedge clk);
        pushVec(vecs[1], !EARLY);
        pushVec(vecs[1], 1'b1);
        for (int i = 0; i < WORD_W + 1 + (EARLY ? 0 : 1) + 1; i++) begin
            checkOutput("b2b_first");
            @(negedge clk);
        end
        instrValid = 1'b0;
        drainChecks("b2b_second");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
